paint_writer: RTL and testbench

Consumer end of the grid's paint interface. On each paint strobe it takes the player-head and new-wall paint commands, queues them in a small FIFO and drains them into a 64x64x4-bit tile memory, one write per cycle. The VGA renderer reads that memory through an independent registered read port. After reset, or on request, a clear sweep zeroes the whole memory.

---
 rtl/paint_writer.sv | 154 +++++++++++++++
 tb/tb_paint_writer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/paint_writer.sv
// Paint command consumer: queues wall/player paint pairs in a small FIFO and
// drains them into a 64x64x4 tile memory; registered read port feeds the VGA side.
module paint_writer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned GRID_BITS  = 6
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     paint_strobe,
  input  logic [2*GRID_BITS-1:0]   player_pos_paint,
  input  logic [3:0]               paint_val_play,
  input  logic [2*GRID_BITS-1:0]   new_wall_pos_paint,
  input  logic [3:0]               paint_val_wall,
  input  logic                     clear_req,
  input  logic [2*GRID_BITS-1:0]   rd_addr,
  output logic [3:0]               rd_data,
  output logic                     busy,
  output logic                     overflow,
  output logic [3:0]               fifo_level
);

  localparam int unsigned AW        = 2 * GRID_BITS;
  localparam int unsigned MEM_DEPTH = 1 << AW;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W     = PTR_W + 1;
  localparam int unsigned FW        = LVL_W + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [3:0]    color;
  } paint_cmd_t;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    sweep_q, sweep_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             overflow_q, overflow_d;
  logic             busy_q, busy_d;
  logic [3:0]       rd_data_q, rd_data_d;

  paint_cmd_t       fifo_q [FIFO_DEPTH];
  logic [3:0]       mem_q  [MEM_DEPTH];

  paint_cmd_t       head;
  paint_cmd_t       wall_cmd;
  paint_cmd_t       play_cmd;
  logic             run_ok;
  logic             pop;
  logic             push;
  logic [FW-1:0]    free_after_pop;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [3:0]       mem_wdata;

  // Next-state, FIFO admission/drain and memory write selection.
  always_comb begin
    state_d        = state_q;
    sweep_d        = sweep_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    level_d        = level_q;
    overflow_d     = overflow_q;
    mem_we         = 1'b0;
    mem_waddr      = sweep_q;
    mem_wdata      = 4'd0;
    head           = fifo_q[rd_ptr_q];
    wall_cmd       = '{addr: new_wall_pos_paint, color: paint_val_wall};
    play_cmd       = '{addr: player_pos_paint,   color: paint_val_play};
    run_ok         = (state_q == S_RUN) && !clear_req;
    pop            = run_ok && (level_q != '0);
    free_after_pop = FW'(FIFO_DEPTH) - FW'(level_q) + FW'(pop);
    push           = paint_strobe && run_ok && (free_after_pop >= FW'(2));

    case (state_q)
      S_CLEAR: begin
        mem_we  = !clear_req;
        sweep_d = sweep_q + AW'(1);
        if (sweep_q == AW'(MEM_DEPTH - 1)) state_d = S_RUN;
      end
      S_RUN: begin
        if (pop) begin
          mem_we    = 1'b1;
          mem_waddr = head.addr;
          mem_wdata = head.color;
        end
      end
      default: state_d = S_CLEAR;
    endcase

    // Both entries of a strobe go in together or not at all.
    if (paint_strobe && !push) overflow_d = 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(2);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    level_d  = level_q - LVL_W'(pop) + (push ? LVL_W'(2) : LVL_W'(0));

    if (clear_req) begin
      state_d  = S_CLEAR;
      sweep_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end

    busy_d    = (state_d == S_CLEAR);
    // Mask reads during the sweep, including the edge that ends it.
    rd_data_d = ((state_q == S_CLEAR) || (state_d == S_CLEAR)) ? 4'd0 : mem_q[rd_addr];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_CLEAR;
      sweep_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b1;
      rd_data_q  <= 4'd0;
    end else begin
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Wall goes in ahead of the player so it drains first.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_q[wr_ptr_q]                      <= wall_cmd;
      fifo_q[PTR_W'(wr_ptr_q + PTR_W'(1))]  <= play_cmd;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign rd_data    = rd_data_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;
  assign fifo_level = 4'(level_q);

endmodule

// File: tb/tb_paint_writer.sv
// Directed bench for paint_writer: clear sweep, strobe timing, FIFO fill/drop,
// clear_req flush and asynchronous reset mid-drain.
module tb_paint_writer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        paint_strobe = 1'b0;
  logic [11:0] player_pos_paint = '0;
  logic [3:0]  paint_val_play = '0;
  logic [11:0] new_wall_pos_paint = '0;
  logic [3:0]  paint_val_wall = '0;
  logic        clear_req = 1'b0;
  logic [11:0] rd_addr = '0;
  logic [3:0]  rd_data;
  logic        busy;
  logic        overflow;
  logic [3:0]  fifo_level;

  int n_vec = 0;
  int n_err = 0;

  paint_writer #(.FIFO_DEPTH(8), .GRID_BITS(6)) dut (
    .clock              (clock),
    .reset              (reset),
    .paint_strobe       (paint_strobe),
    .player_pos_paint   (player_pos_paint),
    .paint_val_play     (paint_val_play),
    .new_wall_pos_paint (new_wall_pos_paint),
    .paint_val_wall     (paint_val_wall),
    .clear_req          (clear_req),
    .rd_addr            (rd_addr),
    .rd_data            (rd_data),
    .busy               (busy),
    .overflow           (overflow),
    .fifo_level         (fifo_level)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns rd_data one cycle later.
  task automatic rd_cell(input logic [11:0] a, output logic [3:0] v);
    rd_addr = a;
    @(negedge clock);
    v = rd_data;
  endtask

  task automatic strobe_set(input logic [11:0] wa, input logic [3:0] wv,
                            input logic [11:0] pa, input logic [3:0] pv);
    new_wall_pos_paint = wa;
    paint_val_wall     = wv;
    player_pos_paint   = pa;
    paint_val_play     = pv;
    paint_strobe       = 1'b1;
  endtask

  // Counts cycles with busy high, starting at the current negedge.
  task automatic sweep_wait(input bit strobe_mid, output int n, output bit rd_nz,
                            output int lvl_max);
    n = 0;
    rd_nz = 1'b0;
    lvl_max = 0;
    while (busy && n < 5000) begin
      n++;
      if (rd_data !== 4'd0) rd_nz = 1'b1;
      if (int'(fifo_level) > lvl_max) lvl_max = int'(fifo_level);
      if (strobe_mid && n == 100) strobe_set(12'h041, 4'h5, 12'h042, 4'h6);
      else paint_strobe = 1'b0;
      rd_addr = 12'($urandom);
      @(negedge clock);
    end
    paint_strobe = 1'b0;
  endtask

  initial begin
    int         n;
    bit         rd_nz;
    int         lvl_max;
    int         k;
    logic [3:0] v;
    int         exp_lvl [10] = '{2, 3, 4, 5, 6, 7, 8, 7, 8, 7};

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_busy", busy, 1);
    chk("rst_overflow", overflow, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_rd_data", rd_data, 0);

    // Initial sweep with a strobe landing mid-clear
    reset = 1'b1;
    sweep_wait(1'b1, n, rd_nz, lvl_max);
    chk("sweep_busy_cycles", n, 4096);
    chk("sweep_rd_zero", rd_nz, 0);
    chk("clear_strobe_level", lvl_max, 0);
    chk("clear_strobe_ovf", overflow, 1);
    rd_cell(12'h041, v); chk("clear_strobe_nowrite", v, 0);
    rd_cell(12'hFFF, v); chk("rd_fff_after_sweep", v, 0);

    // Asynchronous reset while two entries are queued
    strobe_set(12'h600, 4'h7, 12'h601, 4'h8);
    @(negedge clock);
    paint_strobe = 1'b0;
    chk("pre_rst_level", fifo_level, 2);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_rd", rd_data, 0);
    @(negedge clock);
    reset = 1'b1;
    sweep_wait(1'b0, n, rd_nz, lvl_max);
    chk("resweep_busy_cycles", n, 4096);
    rd_cell(12'h600, v); chk("rst_lost_entry", v, 0);

    // Single strobe: level 2,1,0 and same-edge read sees the old value
    strobe_set(12'h041, 4'h2, 12'h042, 4'h0);
    @(negedge clock);
    paint_strobe = 1'b0;
    rd_addr = 12'h041;
    chk("single_lvl_t1", fifo_level, 2);
    @(negedge clock);
    chk("single_lvl_t2", fifo_level, 1);
    chk("same_edge_old", rd_data, 0);
    @(negedge clock);
    chk("single_lvl_t3", fifo_level, 0);
    rd_cell(12'h041, v); chk("single_wall", v, 4'h2);
    rd_cell(12'h042, v); chk("single_player", v, 4'h0);
    chk("single_ovf", overflow, 0);

    // Back-to-back strobes: accepts 0..6 and 8, drops 7 and 9
    for (int i = 0; i < 10; i++) begin
      strobe_set(12'h100 + 12'(i), 4'(i + 3), 12'h300, 4'(i + 1));
      @(negedge clock);
      chk($sformatf("b2b_lvl_%0d", i), fifo_level, exp_lvl[i]);
    end
    paint_strobe = 1'b0;
    k = 0;
    while (fifo_level != 0 && k < 50) begin
      @(negedge clock);
      k++;
    end
    chk("b2b_drained", fifo_level, 0);
    chk("b2b_ovf", overflow, 1);
    for (int i = 0; i < 10; i++) begin
      rd_cell(12'h100 + 12'(i), v);
      chk($sformatf("b2b_wall_%0d", i), v, (i == 7 || i == 9) ? 4'd0 : 4'(i + 3));
    end
    rd_cell(12'h300, v); chk("b2b_last_wins", v, 4'h9);

    // clear_req with three entries queued
    strobe_set(12'h500, 4'hA, 12'h501, 4'hB);
    @(negedge clock);
    chk("cr_lvl_a", fifo_level, 2);
    strobe_set(12'h502, 4'hC, 12'h503, 4'hD);
    @(negedge clock);
    paint_strobe = 1'b0;
    chk("cr_lvl_b", fifo_level, 3);
    clear_req = 1'b1;
    @(negedge clock);
    clear_req = 1'b0;
    chk("cr_flush_level", fifo_level, 0);
    chk("cr_busy", busy, 1);
    sweep_wait(1'b0, n, rd_nz, lvl_max);
    chk("cr_busy_cycles", n, 4096);
    chk("cr_rd_zero", rd_nz, 0);
    rd_cell(12'h041, v); chk("cr_cleared_041", v, 0);
    rd_cell(12'h100, v); chk("cr_cleared_100", v, 0);
    rd_cell(12'h500, v); chk("cr_cleared_500", v, 0);
    rd_cell(12'h503, v); chk("cr_flushed_503", v, 0);
    chk("cr_ovf_sticky", overflow, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
